spi_pixel_receiver: RTL and testbench

SPI_PIXEL_RECEIVER -- requirements
Module: spi_pixel_receiver

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync.sv | 27 ++
 rtl/spi_pixel_receiver.sv | 182 ++++++++++++++++++
 tb/tb_spi_pixel_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI pixel-link definitions: the FSM state type and the default word geometry.
// The receiver and the sender both import these so that they agree on word width and beat count.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_LINES      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } spi_state_e;

  function automatic int spi_beats(input int data_width, input int lines);
    return data_width / lines;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop-chain synchronizer. Every bit uses the same depth, so bits that are sampled
// together leave the chain together. RESET_VAL sets the idle level of each bit.
module spi_sync #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/spi_pixel_receiver.sv
// Receives one DATA_WIDTH pixel word per CS frame over LINES parallel CIPO lines, clocked by DCLK.
// Defining SPI_RX_ERR_CNT_EN adds err_count_out, a 16-bit saturating count of frame errors.
//
// state | meaning
// IDLE  | waiting for a CS fall; DCLK is ignored
// RECV  | shifting in one chunk per DCLK rise
// DONE  | word delivered; extra DCLK rises are overruns; waiting for CS rise
module spi_pixel_receiver
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int LINES       = SPI_LINES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  frame_err_out,
  output logic                  busy_out
`ifdef SPI_RX_ERR_CNT_EN
  ,
  output logic [15:0]           err_count_out
`endif
);

  localparam int BEATS = spi_beats(DATA_WIDTH, LINES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(SYNC_STAGES + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [LINES+1:0]      w_sync_in;
  logic [LINES+1:0]      w_sync_out;
  logic                  w_cs_s;
  logic                  w_clk_s;
  logic [LINES-1:0]      w_data_s;

  logic                  r_cs_prev;
  logic                  r_clk_prev;
  logic [AW-1:0]         r_arm_cnt;
  logic                  r_armed;
  logic                  w_clk_rise;
  logic                  w_cs_rise;
  logic                  w_cs_fall;

  spi_state_e            r_state;
  spi_state_e            w_state_nxt;

  logic                  w_clear;
  logic                  w_shift;
  logic                  w_load;
  logic                  w_err;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [BW-1:0]         r_beat;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_err;

  assign w_sync_in = {chip_sel_in, chip_clk_in, chip_data_in};

  spi_sync #(
    .WIDTH     (LINES + 2),
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL ({1'b1, 1'b0, {LINES{1'b0}}})
  ) u_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_async (w_sync_in),
    .o_sync  (w_sync_out)
  );

  assign w_cs_s   = w_sync_out[LINES+1];
  assign w_clk_s  = w_sync_out[LINES];
  assign w_data_s = w_sync_out[LINES-1:0];

  // A CS held low across reset release looks like a fall once the chain flushes;
  // only accept falls after a settled CS-high has been observed.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cs_prev  <= 1'b1;
      r_clk_prev <= 1'b0;
      r_arm_cnt  <= AW'(SYNC_STAGES);
      r_armed    <= 1'b0;
    end else begin
      r_cs_prev  <= w_cs_s;
      r_clk_prev <= w_clk_s;
      if (r_arm_cnt != '0) r_arm_cnt <= r_arm_cnt - AW'(1);
      else if (w_cs_s)     r_armed   <= 1'b1;
    end
  end

  assign w_clk_rise = w_clk_s & ~r_clk_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;
  assign w_cs_fall  = ~w_cs_s & r_cs_prev & r_armed;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_RECV;
      ST_RECV: begin
        if (w_cs_rise)                                w_state_nxt = ST_IDLE;
        else if (w_clk_rise && (r_beat == LAST_BEAT)) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clear  = 1'b0;
    w_shift  = 1'b0;
    w_load   = 1'b0;
    w_err    = 1'b0;
    busy_out = 1'b0;
    case (r_state)
      ST_IDLE: w_clear = w_cs_fall;
      ST_RECV: begin
        busy_out = 1'b1;
        if (w_cs_rise) begin
          w_err = 1'b1;
        end else if (w_clk_rise) begin
          w_shift = 1'b1;
          w_load  = (r_beat == LAST_BEAT);
        end
      end
      ST_DONE: begin
        busy_out = 1'b1;
        w_err    = w_clk_rise & ~w_cs_rise;
      end
      default: ;
    endcase
  end

  assign w_shift_nxt = DATA_WIDTH'({r_shift, w_data_s});

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift <= '0;
      r_beat  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_err   <= w_err;
      if (w_clear) begin
        r_shift <= '0;
        r_beat  <= '0;
      end else if (w_shift) begin
        r_shift <= w_shift_nxt;
        r_beat  <= r_beat + BW'(1);
      end
      if (w_load) r_data <= w_shift_nxt;
    end
  end

  assign data_out       = r_data;
  assign data_valid_out = r_valid;
  assign frame_err_out  = r_err;

`ifdef SPI_RX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                          r_err_cnt <= '0;
    else if (w_err && (r_err_cnt != '1))    r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_count_out = r_err_cnt;
`endif

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Bench for spi_pixel_receiver: a sender drives frames, a frame-level model predicts the
// sequence of valid words and error pulses, and a monitor checks the DUT against it every cycle.
module tb_spi_pixel_receiver;

  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int BEATS = DW / LN;
  localparam int MAXB  = 16 / LN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LN-1:0] chip_data;
  logic          chip_clk;
  logic          chip_sel;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          err;
  logic          busy;
`ifdef SPI_RX_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  always #5 clk = ~clk;

  spi_pixel_receiver #(.DATA_WIDTH(DW), .LINES(LN), .SYNC_STAGES(2)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .chip_data_in   (chip_data),
    .chip_clk_in    (chip_clk),
    .chip_sel_in    (chip_sel),
    .data_out       (data_out),
    .data_valid_out (valid),
    .frame_err_out  (err),
    .busy_out       (busy)
`ifdef SPI_RX_ERR_CNT_EN
    ,
    .err_count_out  (err_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: expected pulse sequence in order of occurrence.
  typedef struct {
    bit            is_err;
    logic [DW-1:0] val;
  } ev_t;

  ev_t           exp_q[$];
  int            exp_err_total = 0;
  logic [DW-1:0] model_last    = '0;
  int            n_valid_seen  = 0;
  int            n_err_seen    = 0;

  function automatic void model_frame(input logic [15:0] bits, input int nb);
    ev_t e;
    if (nb < BEATS) begin
      e.is_err = 1'b1; e.val = '0;
      exp_q.push_back(e);
      exp_err_total++;
    end else begin
      e.is_err = 1'b0;
      e.val    = DW'(bits >> (16 - DW));
      exp_q.push_back(e);
      for (int k = BEATS; k < nb; k++) begin
        e.is_err = 1'b1; e.val = '0;
        exp_q.push_back(e);
        exp_err_total++;
      end
    end
  endfunction

  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  always @(negedge clk) begin
    bit ok;
    if (!rst_n) begin
      chk("rst_data_out", data_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      model_last = '0;
    end else begin
      if (valid) begin
        n_valid_seen++;
        chk("valid_single_cycle", prev_valid, 0);
        ok = (exp_q.size() != 0) && !exp_q[0].is_err;
        chk("valid_expected", ok, 1);
        if (ok) begin
          chk("valid_data", data_out, exp_q[0].val);
          model_last = exp_q[0].val;
          void'(exp_q.pop_front());
        end
      end
      if (err) begin
        n_err_seen++;
        chk("err_single_cycle", prev_err, 0);
        ok = (exp_q.size() != 0) && exp_q[0].is_err;
        chk("err_expected", ok, 1);
        if (ok) void'(exp_q.pop_front());
      end
      chk("data_hold", data_out, model_last);
    end
    prev_valid = valid;
    prev_err   = err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      wait_cyc(1);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    wait_cyc(10);
  endtask

  // Sends nb chunks taken MSB-first from bits; DCLK half period 'half' clk cycles.
  task automatic send_frame(input logic [15:0] bits, input int nb, input int half,
                            input int gap, input bit chk_busy);
    model_frame(bits, nb);
    chip_sel = 1'b0;
    wait_cyc(half);
    for (int i = 0; i < nb; i++) begin
      chip_data = LN'(bits >> (LN * (MAXB - 1 - i)));
      wait_cyc(half);
      chip_clk = 1'b1;
      wait_cyc(half);
      chip_clk = 1'b0;
      if (i == 0 && chk_busy) chk("busy_in_frame", busy, 1);
    end
    wait_cyc(half);
    chip_sel = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic idle_dclk(input int n);
    for (int i = 0; i < n; i++) begin
      chip_clk  = 1'b1;
      chip_data = LN'($urandom);
      wait_cyc(3);
      chip_clk  = 1'b0;
      wait_cyc(3);
    end
  endtask

  int v0, e0;
`ifdef SPI_RX_ERR_CNT_EN
  logic [15:0] c0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] bits;
    int r, nb;
    rst_n     = 1'b0;
    chip_sel  = 1'b1;
    chip_clk  = 1'b0;
    chip_data = '0;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(8);
    chk("post_rst_data_out", data_out, 0);
    chk("post_rst_busy", busy, 0);

    // single frame, DCLK period 100 clk
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(16'hA500, 2, 50, 5, 1'b1);
    drain();
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid_count", n_valid_seen - v0, 1);
    chk("a5_err_count", n_err_seen - e0, 0);
    chk("a5_idle_busy", busy, 0);

    // back-to-back frames, one-cycle CS-high gap
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(16'h3C00, 2, 10, 1, 1'b1);
    send_frame(16'hF000, 2, 10, 5, 1'b1);
    drain();
    chk("b2b_data", data_out, 8'hF0);
    chk("b2b_valid_count", n_valid_seen - v0, 2);
    chk("b2b_err_count", n_err_seen - e0, 0);

    // abort after one beat
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(16'h7000, 1, 10, 5, 1'b1);
    drain();
    chk("abort_data_kept", data_out, 8'hF0);
    chk("abort_valid_count", n_valid_seen - v0, 0);
    chk("abort_err_count", n_err_seen - e0, 1);

    // overrun: one beat beyond the word
    v0 = n_valid_seen; e0 = n_err_seen;
    send_frame(16'h9630, 3, 8, 5, 1'b1);
    drain();
    chk("overrun_data", data_out, 8'h96);
    chk("overrun_valid_count", n_valid_seen - v0, 1);
    chk("overrun_err_count", n_err_seen - e0, 1);

    // reset in the middle of a frame, then a clean frame
    v0 = n_valid_seen; e0 = n_err_seen;
    chip_sel = 1'b0;
    wait_cyc(10);
    chip_data = 4'h4;
    chip_clk  = 1'b1;
    wait_cyc(6);
    rst_n = 1'b0;
    wait_cyc(5);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(6);
    chip_clk  = 1'b0;
    chip_data = 4'h2;
    wait_cyc(6);
    chip_clk  = 1'b1;
    wait_cyc(6);
    chk("midrst_ignored_busy", busy, 0);
    chip_clk  = 1'b0;
    wait_cyc(6);
    chip_sel  = 1'b1;
    wait_cyc(10);
    chk("midrst_valid_count", n_valid_seen - v0, 0);
    chk("midrst_err_count", n_err_seen - e0, 0);
    send_frame(16'h4200, 2, 10, 5, 1'b1);
    drain();
    chk("post_rst_frame_data", data_out, 8'h42);
    chk("post_rst_frame_valid_count", n_valid_seen - v0, 1);

    // aborted frames and DCLK activity with CS high
    v0 = n_valid_seen; e0 = n_err_seen;
`ifdef SPI_RX_ERR_CNT_EN
    c0 = err_count;
`endif
    send_frame(16'h0000, 0, 6, 4, 1'b0);
    send_frame(16'hB000, 1, 6, 4, 1'b1);
    send_frame(16'h0000, 0, 6, 4, 1'b0);
    drain();
    chk("three_abort_err_count", n_err_seen - e0, 3);
    chk("three_abort_valid_count", n_valid_seen - v0, 0);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_counter_three", err_count - c0, 3);
    c0 = err_count;
`endif
    e0 = n_err_seen;
    idle_dclk(6);
    drain();
    chk("idle_dclk_no_err", n_err_seen - e0, 0);
    chk("idle_dclk_busy", busy, 0);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_counter_idle_dclk", err_count, c0);
`endif

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      bits = 16'($urandom);
      r    = int'($urandom_range(0, 9));
      nb   = (r == 0) ? 0 : (r == 1) ? 1 : (r <= 6) ? 2 : (r <= 8) ? 3 : 4;
      send_frame(bits, nb, int'($urandom_range(3, 12)), int'($urandom_range(1, 6)), 1'b0);
    end
    drain();
    chk("final_idle_busy", busy, 0);
`ifdef SPI_RX_ERR_CNT_EN
    chk("err_counter_total", err_count, exp_err_total);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
